// File: rtl/b1_scfifo_pkg.sv
// b1_scfifo_pkg: shared types and constants for the B1 single-clock FIFO read adapter
package b1_scfifo_pkg;

    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {EMPTY_ST, HALF_ST, FULL_ST} rd_state_t;

    function automatic logic [1:0] occ_of(rd_state_t s);
        return s == FULL_ST ? 2'd2 : s == HALF_ST ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/b1_scfifo_rd_buf.sv
// b1_scfifo_rd_buf: 2-entry ordered output buffer, head shifts on pop, push writes the tail
module b1_scfifo_rd_buf
    import b1_scfifo_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [1:0]        occ_i,
    input  logic [DWIDTH-1:0] din_i,
    output logic [DWIDTH-1:0] head_o
);

    logic [DWIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic              wr_hi;

    // Tail slot is the second entry unless the buffer is (or is becoming) empty.
    assign wr_hi = occ_i == 2'd2 || (occ_i == 2'd1 && !pop_i);

    // Next-state for both slots: a push lands in the tail, a pop moves slot 1 to the head.
    always_comb begin
        d0_d = push_i && !wr_hi ? din_i : pop_i ? d1_q : d0_q;
        d1_d = push_i && wr_hi ? din_i : d1_q;
    end

    // Storage registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            d0_q <= '0;
            d1_q <= '0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
        end
    end

    assign head_o = d0_q;

endmodule

// File: rtl/b1_scfifo_rd_stream.sv
// b1_scfifo_rd_stream: drains a normal-mode FIFO read port into a registered valid/ready stream
module b1_scfifo_rd_stream
    import b1_scfifo_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CWIDTH-1:0] word_cnt_o
);

    rd_state_t         state_q, state_d;
    logic              inflight_q, valid_q, pop;
    logic [1:0]        occ, need;
    logic [CWIDTH-1:0] cnt_q;

    assign occ  = occ_of(state_q);
    assign pop  = valid_q && ready_i;
    // Slots committed after this cycle; a same-cycle pop frees one, so FULL can still issue.
    assign need = occ + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rdreq_o = !arst_i && !fifo_empty_i && need < 2'(RD_BUF_DEPTH);

    // Occupancy transitions: inflight_q marks the cycle fifo_q_i is captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY_ST: if (inflight_q) state_d = HALF_ST;
            HALF_ST:  state_d = inflight_q && !pop ? FULL_ST : !inflight_q && pop ? EMPTY_ST : HALF_ST;
            FULL_ST:  if (pop && !inflight_q) state_d = HALF_ST;
            default:  state_d = EMPTY_ST;
        endcase
    end

    // FSM state with registered valid and the read-in-flight flag.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= EMPTY_ST;
            valid_q    <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= state_d != EMPTY_ST;
            inflight_q <= fifo_rdreq_o;
        end
    end

    // Delivered-word counter, wraps silently.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) cnt_q <= '0;
        else        cnt_q <= cnt_q + CWIDTH'(pop);
    end

    b1_scfifo_rd_buf #(.DWIDTH(DWIDTH)) u_buf (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .push_i (inflight_q),
        .pop_i  (pop),
        .occ_i  (occ),
        .din_i  (fifo_q_i),
        .head_o (data_o)
    );

    assign valid_o    = valid_q;
    assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_b1_scfifo_rd_stream.sv
// tb_b1_scfifo_rd_stream: directed tests of the FIFO read stream adapter against a behavioural FIFO
module tb_b1_scfifo_rd_stream;
    import b1_scfifo_pkg::*;

    logic        clk = 0, arst = 1, ready = 0;
    logic        fifo_empty, rdreq, valid, rdreq_s, valid_s;
    logic [15:0] fifo_q = '0, data, data_s;
    logic [31:0] word_cnt;
    logic [3:0]  cnt_s;

    logic [15:0] fmem [0:255];
    int          wp = 0, rp = 0;
    logic [15:0] got[$];
    int          nreq = 0, viol = 0;
    int          total = 0, passed = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    b1_scfifo_rd_stream dut (
        .clk_i(clk), .arst_i(arst), .fifo_empty_i(fifo_empty), .fifo_q_i(fifo_q),
        .fifo_rdreq_o(rdreq), .data_o(data), .valid_o(valid), .ready_i(ready), .word_cnt_o(word_cnt)
    );

    b1_scfifo_rd_stream #(.DWIDTH(16), .CWIDTH(4)) dut_s (
        .clk_i(clk), .arst_i(arst), .fifo_empty_i(fifo_empty), .fifo_q_i(fifo_q),
        .fifo_rdreq_o(rdreq_s), .data_o(data_s), .valid_o(valid_s), .ready_i(ready), .word_cnt_o(cnt_s)
    );

    assign fifo_empty = (wp == rp);

    always @(posedge clk or posedge arst) begin
        if (arst) rp <= wp;
        else if (rdreq) begin
            fifo_q <= fmem[rp % 256];
            rp     <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (valid && ready) got.push_back(data);
        if (rdreq) nreq <= nreq + 1;
        if ((rdreq && fifo_empty) || (dut.state_q == FULL_ST && dut.inflight_q) ||
            rdreq_s !== rdreq || valid_s !== valid || data_s !== data)
            viol <= viol + 1;
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic samp(); @(negedge clk); #1; endtask

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) fmem[(wp + i) % 256] = base + 16'(i);
        wp = wp + n;
    endtask

    task automatic test_reset();
        load(1, 16'h0BAD);
        #1;
        total++; if (rdreq !== 1'b0) $display("FAIL reset_rdreq got=%b exp=0", rdreq); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passed++;
        total++; if (data !== 16'h0) $display("FAIL reset_data got=%h exp=0000", data); else passed++;
        total++; if (word_cnt !== 32'h0) $display("FAIL reset_cnt got=%h exp=0", word_cnt); else passed++;
        total++; if (dut.state_q !== EMPTY_ST) $display("FAIL reset_state got=%0d exp=EMPTY_ST", dut.state_q); else passed++;
        tick(); tick();
        arst = 0;
        tick();
    endtask

    task automatic test_latency_throughput();
        int gb, bad;
        gb = got.size(); bad = 0;
        tick(); ready = 1; load(8, 16'h0001);
        samp();
        total++; if (rdreq !== 1'b1 || valid !== 1'b0) $display("FAIL lat_n rdreq=%b valid=%b exp rdreq=1 valid=0", rdreq, valid); else passed++;
        tick(); samp();
        total++; if (valid !== 1'b0) $display("FAIL lat_n1 valid=%b exp=0", valid); else passed++;
        tick(); samp();
        total++; if (valid !== 1'b1 || data !== 16'h0001) $display("FAIL lat_n2 valid=%b data=%h exp valid=1 data=0001", valid, data); else passed++;
        for (int i = 0; i < 40 && got.size() < gb + 8; i++) samp();
        total++; if (got.size() - gb != 8) $display("FAIL thr_count got=%0d exp=8", got.size() - gb); else passed++;
        for (int i = 0; i < 8 && gb + i < got.size(); i++) if (got[gb + i] !== 16'(i + 1)) bad++;
        total++; if (bad != 0) $display("FAIL thr_order bad=%0d exp=0", bad); else passed++;
        exp_cnt += 8;
        tick(); tick(); tick();
        total++; if (word_cnt !== 32'(exp_cnt)) $display("FAIL thr_cnt got=%0d exp=%0d", word_cnt, exp_cnt); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL thr_idle valid=%b exp=0", valid); else passed++;
    endtask

    task automatic test_backpressure();
        int gb, bad, n0;
        gb = got.size(); bad = 0;
        tick(); ready = 0; load(8, 16'h0001); n0 = nreq;
        for (int k = 0; k < 10; k++) begin
            samp();
            if (k >= 2 && (valid !== 1'b1 || data !== 16'h0001)) bad++;
            tick();
        end
        total++; if (nreq - n0 != 2) $display("FAIL stall_rdreq got=%0d exp=2", nreq - n0); else passed++;
        total++; if (bad != 0) $display("FAIL stall_hold bad=%0d exp=0", bad); else passed++;
        ready = 1;
        bad = 0;
        for (int i = 0; i < 40 && got.size() < gb + 8; i++) samp();
        for (int i = 0; i < 8 && gb + i < got.size(); i++) if (got[gb + i] !== 16'(i + 1)) bad++;
        total++; if (got.size() - gb != 8 || bad != 0) $display("FAIL stall_order count=%0d bad=%0d exp count=8 bad=0", got.size() - gb, bad); else passed++;
        exp_cnt += 8;
        tick(); tick(); tick();
        total++; if (word_cnt !== 32'(exp_cnt)) $display("FAIL stall_cnt got=%0d exp=%0d", word_cnt, exp_cnt); else passed++;
    endtask

    task automatic test_toggle();
        int gb, bad, v0;
        gb = got.size(); bad = 0; v0 = viol;
        tick(); ready = 1; load(16, 16'h0100);
        for (int i = 0; i < 100 && got.size() < gb + 16; i++) begin
            samp(); tick(); ready = !ready;
        end
        ready = 1;
        for (int i = 0; i < 16 && gb + i < got.size(); i++) if (got[gb + i] !== 16'h0100 + 16'(i)) bad++;
        total++; if (got.size() - gb != 16 || bad != 0) $display("FAIL toggle_order count=%0d bad=%0d exp count=16 bad=0", got.size() - gb, bad); else passed++;
        exp_cnt += 16;
        tick(); tick(); tick();
        total++; if (viol != v0) $display("FAIL toggle_invariant got=%0d exp=0", viol - v0); else passed++;
        total++; if (word_cnt !== 32'(exp_cnt)) $display("FAIL toggle_cnt got=%0d exp=%0d", word_cnt, exp_cnt); else passed++;
    endtask

    task automatic test_single_word();
        int gb, n0;
        gb = got.size();
        tick(); ready = 1; n0 = nreq; load(1, 16'h00A5);
        repeat (6) tick();
        samp();
        total++; if (got.size() - gb != 1 || got[got.size() - 1] !== 16'h00A5) $display("FAIL single_beat count=%0d exp=1 value 00a5", got.size() - gb); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL single_valid got=%b exp=0", valid); else passed++;
        total++; if (dut.state_q !== EMPTY_ST) $display("FAIL single_state got=%0d exp=EMPTY_ST", dut.state_q); else passed++;
        total++; if (nreq - n0 != 1) $display("FAIL single_rdreq got=%0d exp=1", nreq - n0); else passed++;
        exp_cnt += 1;
    endtask

    task automatic test_wrap();
        int n;
        n = 15 - (exp_cnt % 16);
        tick(); ready = 1; load(n, 16'h0300);
        repeat (n + 6) tick();
        exp_cnt += n;
        total++; if (cnt_s !== 4'hF) $display("FAIL wrap_pre got=%h exp=f", cnt_s); else passed++;
        load(1, 16'h03FF);
        repeat (6) tick();
        exp_cnt += 1;
        total++; if (cnt_s !== 4'h0) $display("FAIL wrap_zero got=%h exp=0", cnt_s); else passed++;
        total++; if (word_cnt !== 32'(exp_cnt)) $display("FAIL wrap_wide got=%0d exp=%0d", word_cnt, exp_cnt); else passed++;
    endtask

    task automatic test_async_reset();
        tick(); ready = 1; load(8, 16'h0200);
        repeat (4) tick();
        samp();
        total++; if (valid !== 1'b1 || dut.inflight_q !== 1'b1) $display("FAIL arst_pre valid=%b inflight=%b exp 1 1", valid, dut.inflight_q); else passed++;
        arst = 1;
        #1;
        total++; if (valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", valid); else passed++;
        total++; if (word_cnt !== 32'h0) $display("FAIL arst_cnt got=%0d exp=0", word_cnt); else passed++;
        total++; if (rdreq !== 1'b0) $display("FAIL arst_rdreq got=%b exp=0", rdreq); else passed++;
        total++; if (dut.inflight_q !== 1'b0) $display("FAIL arst_inflight got=%b exp=0", dut.inflight_q); else passed++;
        tick(); arst = 0; exp_cnt = 0;
        repeat (3) tick();
        samp();
        total++; if (valid !== 1'b0 || word_cnt !== 32'h0) $display("FAIL arst_after valid=%b cnt=%0d exp 0 0", valid, word_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency_throughput();
        test_backpressure();
        test_toggle();
        test_single_word();
        test_wrap();
        test_async_reset();
        total++; if (viol != 0) $display("FAIL invariants got=%0d exp=0", viol); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
